// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the byte-serial data-memory sequencer (dmem_access_ctrl).
// The build option DMEM_UNALIGNED_ACCESS_EN is consumed by the top module only.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    // Reserved size maps to one byte; it is rejected before any access is made.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Load result formatting: the right-aligned accumulator is sign- or zero-extended
// from 8 or 16 bits; a word passes through unchanged.
module dmem_load_extend
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    // Extension select by access size.
    always_comb begin
        rdata = 32'h0000_0000;
        case (size)
            SZ_BYTE: rdata = {{24{sign_ext & acc[7]}}, acc[7:0]};
            SZ_HALF: rdata = {{16{sign_ext & acc[15]}}, acc[15:0]};
            SZ_WORD: rdata = acc;
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Runs byte/half/word loads and stores as big-endian single-byte data_mem accesses.
// Define DMEM_UNALIGNED_ACCESS_EN to accept misaligned half/word addresses.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_write_data,
    output logic                  mem_MemWrite,
    output logic                  mem_MemRead,
    input  logic [7:0]            mem_read_data
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           acc_q, acc_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            idx_q, idx_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic                  sgn_q, sgn_d;
    logic                  rd_q, rd_d;
    logic                  err_q, err_d;

    logic                  misaligned;
    logic                  req_err;
    logic                  last_byte;
    logic [1:0]            byte_sel;
    logic [7:0]            store_byte;
    logic [31:0]           ext_rdata;

    dmem_load_extend u_extend (
        .acc      (acc_q),
        .size     (size_q),
        .sign_ext (sgn_q),
        .rdata    (ext_rdata)
    );

    // Request validation and store-byte selection (most significant byte first).
    always_comb begin
`ifdef DMEM_UNALIGNED_ACCESS_EN
        misaligned = 1'b0;
`else
        misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`endif
        req_err   = (req_read && req_write) || (req_size == SZ_RSVD) || misaligned;
        last_byte = ({1'b0, idx_q} == (nbytes_q - 3'd1));
        byte_sel  = 2'(nbytes_q - 3'd1 - {1'b0, idx_q});
        case (byte_sel)
            2'd0:    store_byte = wdata_q[7:0];
            2'd1:    store_byte = wdata_q[15:8];
            2'd2:    store_byte = wdata_q[23:16];
            default: store_byte = wdata_q[31:24];
        endcase
    end

    // Next-state logic; a request dropped mid-access still completes from latched values.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        acc_d    = acc_q;
        size_d   = size_q;
        idx_d    = idx_q;
        nbytes_d = nbytes_q;
        sgn_d    = sgn_q;
        rd_d     = rd_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_read || req_write) begin
                    base_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size;
                    sgn_d    = req_signed;
                    rd_d     = req_read;
                    nbytes_d = size_to_nbytes(req_size);
                    idx_d    = 2'd0;
                    acc_d    = 32'h0000_0000;
                    err_d    = req_err;
                    state_d  = req_err ? DONE : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (rd_q) begin
                    acc_d = {acc_q[23:0], mem_read_data};
                end else begin
                    acc_d = acc_q;
                end
                idx_d = idx_q + 2'd1;
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    state_d = ACCESS;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request-latch registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            wdata_q  <= 32'h0000_0000;
            acc_q    <= 32'h0000_0000;
            size_q   <= 2'b00;
            idx_q    <= 2'd0;
            nbytes_q <= 3'd0;
            sgn_q    <= 1'b0;
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            acc_q    <= acc_d;
            size_q   <= size_d;
            idx_q    <= idx_d;
            nbytes_q <= nbytes_d;
            sgn_q    <= sgn_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded from state; held quiet while reset is asserted so no byte slips out.
    always_comb begin
        stall          = (req_read || req_write) && (state_q != DONE);
        resp_valid     = 1'b0;
        resp_err       = 1'b0;
        resp_rdata     = 32'h0000_0000;
        mem_address    = '0;
        mem_write_data = 8'h00;
        mem_MemWrite   = 1'b0;
        mem_MemRead    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ACCESS: begin
                    mem_address = base_q + ADDR_WIDTH'(idx_q);
                    if (rd_q) begin
                        mem_MemRead = 1'b1;
                    end else begin
                        mem_MemWrite   = 1'b1;
                        mem_write_data = store_byte;
                    end
                end
                DONE: begin
                    resp_valid = 1'b1;
                    resp_err   = err_q;
                    if (rd_q && !err_q) begin
                        resp_rdata = ext_rdata;
                    end else begin
                        resp_rdata = 32'h0000_0000;
                    end
                end
                default: resp_valid = 1'b0;
            endcase
        end else begin
            resp_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 256-byte data_mem model (low address byte).
// Checks both builds of DMEM_UNALIGNED_ACCESS_EN.
module tb_dmem_access_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          req_read, req_write, req_signed;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          stall, resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_write_data, mem_read_data;
    logic          mem_MemWrite, mem_MemRead;

    logic [7:0]    mem [0:255] = '{default: 8'h00};
    logic          pre_we;
    logic [7:0]    pre_a, pre_d;

    int checks = 0;
    int errors = 0;

    int          lat, nrd, nwr, nst, nboth, nlog;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [31:0] alog [0:7];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    dmem_access_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_MemWrite   (mem_MemWrite),
        .mem_MemRead    (mem_MemRead),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_MemWrite) mem[mem_address[7:0]] <= mem_write_data;
        else if (pre_we)  mem[pre_a] <= pre_d;
    end
    assign mem_read_data = mem[mem_address[7:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one request (cycle 0 = IDLE) and log strobes until resp_valid or budget.
    task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd, input int drop_at);
        @(posedge clk); #1;
        req_read = rd; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        lat = -1; nrd = 0; nwr = 0; nst = 0; nboth = 0; nlog = 0;
        got_rdata = 32'hxxxx_xxxx; got_err = 1'bx;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stall) nst++;
            if (mem_MemRead) nrd++;
            if (mem_MemWrite) nwr++;
            if (mem_MemRead && mem_MemWrite) nboth++;
            if ((mem_MemRead || mem_MemWrite) && nlog < 8) begin
                alog[nlog] = mem_address;
                nlog++;
            end
            if (c == drop_at) begin
                req_read = 1'b0; req_write = 1'b0;
            end
            if (resp_valid) begin
                lat = c; got_rdata = resp_rdata; got_err = resp_err;
                break;
            end
        end
        req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic chk_result(input string nm, input logic [31:0] rdata, input logic err,
                              input int elat, input int enrd, input int enwr);
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_rdata"}, got_rdata, rdata);
        chk({nm, "_err"}, {31'd0, got_err}, {31'd0, err});
        chk({nm, "_nread"}, 32'(nrd), 32'(enrd));
        chk({nm, "_nwrite"}, 32'(nwr), 32'(enwr));
        chk({nm, "_both"}, 32'(nboth), 32'd0);
    endtask

    initial begin
        // rd wr size sgn addr wdata exp_rdata err lat nrd nwr
        vecs[0]  = '{1'b0, 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h1122_3344, 32'h0000_0000, 1'b0, 5, 0, 4};
        vecs[1]  = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0,         32'h1122_3344, 1'b0, 5, 4, 0};
        vecs[2]  = '{1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h0A, 32'h0000_0080, 32'h0000_0000, 1'b0, 2, 0, 1};
        vecs[3]  = '{1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h0B, 32'hFFFF_FF01, 32'h0000_0000, 1'b0, 2, 0, 1};
        vecs[4]  = '{1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0A, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 1, 0};
        vecs[5]  = '{1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0A, 32'h0,         32'h0000_0080, 1'b0, 2, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0,         32'hFFFF_8001, 1'b0, 3, 2, 0};
        vecs[7]  = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0,         32'h0000_8001, 1'b0, 3, 2, 0};
        vecs[8]  = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0,         32'h1122_8001, 1'b0, 5, 4, 0};
        vecs[9]  = '{1'b0, 1'b1, SZ_HALF, 1'b0, 32'h10, 32'hABCD_BEEF, 32'h0000_0000, 1'b0, 3, 0, 2};
        vecs[10] = '{1'b1, 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0,         32'hBEEF_0000, 1'b0, 5, 4, 0};
        vecs[11] = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0,         32'hFFFF_BEEF, 1'b0, 3, 2, 0};
        vecs[12] = '{1'b1, 1'b1, SZ_WORD, 1'b0, 32'h00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 0, 0};
        vecs[13] = '{1'b1, 1'b0, SZ_RSVD, 1'b1, 32'h00, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 0};
        vecs[14] = '{1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h1234_565A, 32'h0000_0000, 1'b0, 2, 0, 1};
        vecs[15] = '{1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,         32'h0000_005A, 1'b0, 2, 1, 0};
        vecs[16] = '{1'b0, 1'b1, SZ_RSVD, 1'b0, 32'h20, 32'h5555_5555, 32'h0000_0000, 1'b1, 1, 0, 0};

        rst_n = 1'b0; pre_we = 1'b0; pre_a = 8'h00; pre_d = 8'h00;
        req_read = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_write_data}, 32'd0);
        chk("rst_memwrite", {31'd0, mem_MemWrite}, 32'd0);
        chk("rst_memread", {31'd0, mem_MemRead}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, -1);
            chk_result($sformatf("v%0d", i), vecs[i].rdata, vecs[i].err,
                       vecs[i].lat, vecs[i].nrd, vecs[i].nwr);
            chk($sformatf("v%0d_stall_cycles", i), 32'(nst), 32'(vecs[i].lat));
            for (int k = 0; k < nlog; k++)
                chk($sformatf("v%0d_addr%0d", i, k), alog[k], vecs[i].addr + 32'(k));
            if (i == 0) begin
                chk("store_word_mem8", {24'd0, mem[8'h08]}, 32'h11);
                chk("store_word_mem9", {24'd0, mem[8'h09]}, 32'h22);
                chk("store_word_memA", {24'd0, mem[8'h0A]}, 32'h33);
                chk("store_word_memB", {24'd0, mem[8'h0B]}, 32'h44);
            end
        end
        chk("final_mem8",  {24'd0, mem[8'h08]}, 32'h11);
        chk("final_memA",  {24'd0, mem[8'h0A]}, 32'h80);
        chk("final_memB",  {24'd0, mem[8'h0B]}, 32'h01);
        chk("final_mem10", {24'd0, mem[8'h10]}, 32'hBE);
        chk("final_mem11", {24'd0, mem[8'h11]}, 32'hEF);
        chk("final_mem12", {24'd0, mem[8'h12]}, 32'h00);
        chk("final_mem13", {24'd0, mem[8'h13]}, 32'h5A);

        // Request dropped after the first ACCESS cycle still completes.
        run_req(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0, 1);
        chk_result("drop_half", 32'hFFFF_8001, 1'b0, 3, 2, 0);

        preload(8'hFE, 8'hA1);
        preload(8'hFF, 8'hB2);
        preload(8'h00, 8'hC3);
        preload(8'h01, 8'hD4);
`ifdef DMEM_UNALIGNED_ACCESS_EN
        run_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, -1);
        chk_result("unal_word6", 32'h0000_1122, 1'b0, 5, 4, 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("unal_word6_addr%0d", k), alog[k], 32'h06 + 32'(k));
        run_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFE, 32'h0, -1);
        chk_result("wrap_word", 32'hA1B2_C3D4, 1'b0, 5, 4, 0);
        chk("wrap_addr0", alog[0], 32'hFFFF_FFFE);
        chk("wrap_addr1", alog[1], 32'hFFFF_FFFF);
        chk("wrap_addr2", alog[2], 32'h0000_0000);
        chk("wrap_addr3", alog[3], 32'h0000_0001);
        run_req(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h11, 32'h0, -1);
        chk_result("unal_half11", 32'hFFFF_EF00, 1'b0, 3, 2, 0);
`else
        run_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, -1);
        chk_result("unal_word6", 32'h0, 1'b1, 1, 0, 0);
        run_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFE, 32'h0, -1);
        chk_result("wrap_word", 32'h0, 1'b1, 1, 0, 0);
        run_req(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h11, 32'h0, -1);
        chk_result("unal_half11", 32'h0, 1'b1, 1, 0, 0);
        run_req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h21, 32'hCAFE_F00D, -1);
        chk_result("unal_store21", 32'h0, 1'b1, 1, 0, 0);
`endif

        // Reset in the ACCESS cycle after two bytes of a word store.
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0; req_write = 1'b0;
        @(negedge clk);
        chk("rstmid_memwrite_low", {31'd0, mem_MemWrite}, 32'd0);
        @(posedge clk); #1;
        chk("rstmid_stall", {31'd0, stall}, 32'd0);
        chk("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstmid_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rstmid_rdata", resp_rdata, 32'd0);
        chk("rstmid_addr", mem_address, 32'd0);
        chk("rstmid_wdata", {24'd0, mem_write_data}, 32'd0);
        chk("rstmid_memread", {31'd0, mem_MemRead}, 32'd0);
        rst_n = 1'b1;
        nst = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid || mem_MemWrite) nst++;
        end
        chk("rstmid_no_activity", 32'(nst), 32'd0);
        chk("rstmid_mem20", {24'd0, mem[8'h20]}, 32'hDE);
        chk("rstmid_mem21", {24'd0, mem[8'h21]}, 32'hAD);
        chk("rstmid_mem22", {24'd0, mem[8'h22]}, 32'h00);
        chk("rstmid_mem23", {24'd0, mem[8'h23]}, 32'h00);

        run_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, -1);
        chk_result("post_rst_load", 32'hDEAD_0000, 1'b0, 5, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
